ram_burst_master: RTL and testbench

Initiator for the 32×32 single-port RAM: takes burst requests from the control unit and drives the RAM's address/data/write-enable/chip-select port. Writes are pulled from a valid/ready stream, and reads are pushed into a valid/ready stream through a 2-entry buffer. It sits between the SCIC datapath (or a DMA-style loader) and the RAM. It is the only driver of the RAM port.

---
 rtl/ram_burst_master.sv | 172 +++++++++++++++++
 tb/tb_ram_burst_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_master.sv
// Burst initiator for a 32x32 single-port RAM: the master acts on posedge and the RAM on negedge.
// Defining RAM_MASTER_VERIFY_EN adds a readback check after every write, reported on verify_err.
module ram_burst_master #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  dir,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [5:0]            length,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  ram_we,
    output logic                  ram_cs,
    output logic                  verify_err
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [5:0]              remaining;
    logic [DATA_WIDTH-1:0]   buf_mem [2];
    logic                    buf_rd_ptr;
    logic                    buf_wr_ptr;
    logic [1:0]              buf_count;
    logic                    rd_inflight;
    logic                    ver_pend;
    logic                    ver_chk;
    logic                    pop;
    logic                    wr_fire;
    logic                    rd_issue;
    logic                    drain_ok;
    logic [1:0]              occ;

    assign rd_valid = (buf_count != 2'd0);
    assign rd_data  = buf_mem[buf_rd_ptr];
    assign pop      = rd_valid && rd_ready;
    assign wr_ready = (state == WRITE) && (remaining != 6'd0) && !ver_pend;
    assign wr_fire  = wr_valid && wr_ready;

    // Occupancy after this edge's capture and pop; a new issue must still fit in the 2-entry buffer.
    assign occ      = buf_count + {1'b0, rd_inflight} - {1'b0, pop};
    assign rd_issue = (state == READ) && (remaining != 6'd0) && (occ < 2'd2);
    assign drain_ok = !rd_inflight && ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            done   <= 1'b0;
            ram_cs <= 1'b0;
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= (length > 6'd32) ? 6'd32 : length;
                        if (length == 6'd0) begin
                            state <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= dir ? WRITE : READ;
                        end
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        ram_cs    <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_addr  <= addr;
                        ram_wdata <= wr_data;
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 6'd1;
                    end else if (ver_pend) begin
                        // Readback of the word just written; ram_addr still holds its address.
                        ram_cs <= 1'b1;
                    end else if ((remaining == 6'd0) && !ver_chk) begin
                        state <= DONE;
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        ram_cs    <= 1'b1;
                        ram_addr  <= addr;
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 6'd1;
                        if (remaining == 6'd1) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_ok) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read buffer: data arrives one edge after its issue.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                buf_mem[i] <= '0;
            end
            buf_rd_ptr  <= 1'b0;
            buf_wr_ptr  <= 1'b0;
            buf_count   <= 2'd0;
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= rd_issue;
            if (rd_inflight) begin
                buf_mem[buf_wr_ptr] <= ram_rdata;
                buf_wr_ptr          <= ~buf_wr_ptr;
            end
            if (pop) begin
                buf_rd_ptr <= ~buf_rd_ptr;
            end
            buf_count <= buf_count + {1'b0, rd_inflight} - {1'b0, pop};
        end
    end

`ifdef RAM_MASTER_VERIFY_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ver_pend   <= 1'b0;
            ver_chk    <= 1'b0;
            verify_err <= 1'b0;
        end else begin
            ver_pend <= wr_fire;
            ver_chk  <= ver_pend;
            if ((state == IDLE) && start) begin
                verify_err <= 1'b0;
            end else if (ver_chk && (ram_rdata != ram_wdata)) begin
                verify_err <= 1'b1;
            end
        end
    end
`else
    assign ver_pend   = 1'b0;
    assign ver_chk    = 1'b0;
    assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_burst_master.sv
// Table-driven bench for ram_burst_master with a negedge RAM model; honours RAM_MASTER_VERIFY_EN.
module tb_ram_burst_master;

    logic        clock;
    logic        reset;
    logic        start;
    logic        dir;
    logic [4:0]  base_addr;
    logic [5:0]  length;
    logic        busy;
    logic        done;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_we;
    logic        ram_cs;
    logic        verify_err;

    logic [31:0] mem [32];
    logic        corrupt_en;
    int          n_chk;
    int          n_fail;

    ram_burst_master #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .dir(dir),
        .base_addr(base_addr), .length(length), .busy(busy), .done(done),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ram_we(ram_we), .ram_cs(ram_cs), .verify_err(verify_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // RAM model; address 5 reads back with bit 0 flipped when corrupt_en is set.
    always @(negedge clock) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else ram_rdata <= (corrupt_en && ram_addr == 5'd5) ? (mem[ram_addr] ^ 32'h1) : mem[ram_addr];
        end else begin
            ram_rdata <= 'x;
        end
    end

    typedef struct {
        logic dir;
        int   base;
        int   len;
        int   seed;
        int   stall;
        int   poke;
        int   corrupt;
        int   exp_done;
        int   exp_first;
        int   exp_verr;
    } vec_t;

`ifdef RAM_MASTER_VERIFY_EN
    localparam int WMUL = 2;
    localparam int WADD = 3;
    localparam int VERR = 1;
`else
    localparam int WMUL = 1;
    localparam int WADD = 2;
    localparam int VERR = 0;
`endif

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n, k, widx, ridx, first, cs_cnt, stall_iss, done_k;
        logic busy0;
        string p;
        p = $sformatf("v%0d", idx);
        n = (v.len > 32) ? 32 : v.len;
        corrupt_en = (v.corrupt != 0);
        @(negedge clock);
        start = 1'b1; dir = v.dir; base_addr = v.base[4:0]; length = v.len[5:0];
        wr_data = v.seed; wr_valid = 1'b1; rd_ready = (v.stall == 0);
        @(posedge clock);
        k = 0; widx = 0; ridx = 0; first = -1; cs_cnt = 0; stall_iss = 0; done_k = -1;
        @(negedge clock);
        start = 1'b0;
        busy0 = busy;
        while (k < 200) begin
            if (done) begin
                done_k = k;
                break;
            end
            rd_ready = (k >= v.stall);
            if (ram_cs && ram_we == v.dir) cs_cnt++;
            if (k < v.stall && ram_cs && !ram_we) stall_iss++;
            if (rd_valid && first < 0) first = k;
            if (rd_valid && rd_ready) begin
                chk({p, "_rd_data"}, rd_data, v.seed + ridx);
                ridx++;
            end
            wr_data = v.seed + widx;
            if (wr_ready) widx++;
            if (k == v.poke) begin
                start = 1'b1; dir = ~v.dir; base_addr = 5'd0; length = 6'd5;
            end
            if (k == v.poke + 1) start = 1'b0;
            @(posedge clock);
            k++;
            @(negedge clock);
        end
        chk({p, "_done_latency"}, done_k, v.exp_done);
        chk({p, "_busy_after_start"}, busy0, (n != 0));
        chk({p, "_first_rd_valid"}, first, v.exp_first);
        chk({p, "_words"}, v.dir ? widx : ridx, n);
        chk({p, "_ram_accesses"}, cs_cnt, n);
        if (v.stall > 0) chk({p, "_issues_during_stall"}, stall_iss, 2);
        chk({p, "_verify_err"}, verify_err, v.exp_verr);
        @(posedge clock);
        @(negedge clock);
        chk({p, "_done_single_pulse"}, done, 0);
        chk({p, "_busy_low_after"}, busy, 0);
        if (v.dir) begin
            for (int i = 0; i < n; i++) begin
                chk($sformatf("%s_mem[%0d]", p, (v.base + i) % 32), mem[(v.base + i) % 32], v.seed + i);
            end
        end
        wr_valid = 1'b0;
    endtask

    vec_t vecs [12];
    vec_t v0;

    initial begin
        n_chk = 0; n_fail = 0; corrupt_en = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        reset = 1'b1; start = 1'b0; dir = 1'b0; base_addr = '0; length = '0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;

        //          dir   base len seed    stall poke crpt exp_done          first verr
        vecs[0]  = '{1'b1,  3,  4, 'hA0,  0, -1, 0, WMUL*4 + WADD,  -1, 0};
        vecs[1]  = '{1'b0,  3,  4, 'hA0,  0, -1, 0, 7,               2, 0};
        vecs[2]  = '{1'b1, 30,  4, 'hB0,  0, -1, 0, WMUL*4 + WADD,  -1, 0};
        vecs[3]  = '{1'b0, 30,  4, 'hB0,  0, -1, 0, 7,               2, 0};
        vecs[4]  = '{1'b1,  0,  0, 'h00,  0, -1, 0, 1,              -1, 0};
        vecs[5]  = '{1'b1, 20,  3, 'hD0,  0,  2, 0, WMUL*3 + WADD,  -1, 0};
        vecs[6]  = '{1'b1, 10, 40, 'hC0,  0, -1, 0, WMUL*32 + WADD, -1, 0};
        vecs[7]  = '{1'b0, 10, 32, 'hC0,  0, -1, 0, 35,              2, 0};
        vecs[8]  = '{1'b0, 10,  8, 'hC0, 10, -1, 0, 19,              2, 0};
        vecs[9]  = '{1'b0,  0,  0, 'h00,  0, -1, 0, 1,              -1, 0};
        vecs[10] = '{1'b1,  5,  2, 'hE0,  0, -1, 1, WMUL*2 + WADD,  -1, VERR};
        vecs[11] = '{1'b1,  8,  1, 'hF0,  0, -1, 1, WMUL*1 + WADD,  -1, 0};

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_ram_cs", ram_cs, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_verify_err", verify_err, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_rd_data", rd_data, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Reset in the middle of a read burst aborts everything at once.
        corrupt_en = 1'b0;
        @(negedge clock);
        start = 1'b1; dir = 1'b0; base_addr = 5'd10; length = 6'd8; rd_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk("midrd_ram_cs_before", ram_cs, 1);
        chk("midrd_rd_valid_before", rd_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("midrd_ram_cs_reset", ram_cs, 0);
        chk("midrd_rd_valid_reset", rd_valid, 0);
        chk("midrd_busy_reset", busy, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("midrd_rd_valid_after", rd_valid, 0);
        chk("midrd_ram_cs_after", ram_cs, 0);
        chk("midrd_busy_after", busy, 0);

        v0 = '{1'b0, 10, 2, 'hC0, 0, -1, 0, 5, 2, 0};
        run_vec(v0, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
